// File: rtl/jtag_dual_user_tap.sv
// jtag_dual_user_tap: IEEE 1149.1 TAP controller with a 10-bit IR and two
// BSCAN-style user ports (USER1 function-code chain, USER2 register chain).
// Optional feature macro: JTAG_IDCODE_EN. When defined, it adds the IDCODE
// instruction (10'h3C9) and the 32-bit ID register, and TLR selects IDCODE.
// When undefined, 10'h3C9 acts as BYPASS and TLR selects BYPASS.
module jtag_dual_user_tap #(
    parameter logic [9:0]  USER1_CODE = 10'h3C2,
    parameter logic [9:0]  USER2_CODE = 10'h3C3,
    parameter logic [31:0] IDCODE_VAL = 32'h0424A093
) (
    input  logic TCK,
    input  logic RST_N,
    input  logic TMS,
    input  logic TDI,
    input  logic TDO1,
    input  logic TDO2,
    output logic TDO,
    output logic TDO_EN,
    output logic CAPTURE1,
    output logic DRCK1,
    output logic RESET1,
    output logic RUNTEST1,
    output logic SEL1,
    output logic SHIFT1,
    output logic UPDATE1,
    output logic TCK1,
    output logic TDI1,
    output logic TMS1,
    output logic CAPTURE2,
    output logic DRCK2,
    output logic RESET2,
    output logic RUNTEST2,
    output logic SEL2,
    output logic SHIFT2,
    output logic UPDATE2,
    output logic TCK2,
    output logic TDI2,
    output logic TMS2
);

    typedef enum logic [3:0] {
        S_TLR, S_RTI,
        S_SELDR, S_CAPDR, S_SHDR, S_EX1DR, S_PAUSEDR, S_EX2DR, S_UPDDR,
        S_SELIR, S_CAPIR, S_SHIR, S_EX1IR, S_PAUSEIR, S_EX2IR, S_UPDIR
    } tap_state_t;

    localparam logic [9:0] IR_CAPTURE = 10'b0000000001;
    localparam logic [9:0] IR_IDCODE  = 10'h3C9;

`ifdef JTAG_IDCODE_EN
    localparam logic [9:0] IR_RESET = IR_IDCODE;
`else
    localparam logic [9:0] IR_RESET = 10'h3FF;
    // Bypass always captures 0; the ID value is folded in only so the
    // parameter stays referenced when the ID register is compiled out.
    localparam logic BYP_CAPTURE = 1'b0 & IDCODE_VAL[0];
`endif

    // Standard TAP transition table.
    function automatic tap_state_t f_next(input tap_state_t s, input logic tms);
        case (s)
            S_TLR:     f_next = tms ? S_TLR   : S_RTI;
            S_RTI:     f_next = tms ? S_SELDR : S_RTI;
            S_SELDR:   f_next = tms ? S_SELIR : S_CAPDR;
            S_CAPDR:   f_next = tms ? S_EX1DR : S_SHDR;
            S_SHDR:    f_next = tms ? S_EX1DR : S_SHDR;
            S_EX1DR:   f_next = tms ? S_UPDDR : S_PAUSEDR;
            S_PAUSEDR: f_next = tms ? S_EX2DR : S_PAUSEDR;
            S_EX2DR:   f_next = tms ? S_UPDDR : S_SHDR;
            S_UPDDR:   f_next = tms ? S_SELDR : S_RTI;
            S_SELIR:   f_next = tms ? S_TLR   : S_CAPIR;
            S_CAPIR:   f_next = tms ? S_EX1IR : S_SHIR;
            S_SHIR:    f_next = tms ? S_EX1IR : S_SHIR;
            S_EX1IR:   f_next = tms ? S_UPDIR : S_PAUSEIR;
            S_PAUSEIR: f_next = tms ? S_EX2IR : S_PAUSEIR;
            S_EX2IR:   f_next = tms ? S_UPDIR : S_SHIR;
            S_UPDIR:   f_next = tms ? S_SELDR : S_RTI;
            default:   f_next = S_TLR;
        endcase
    endfunction

    tap_state_t r_state;
    tap_state_t w_next;
    logic       r_reset;
    logic       r_runtest;
    logic       r_capture;
    logic       r_shift;
    logic       r_update;
    logic [9:0] r_ir_sr;
    logic [9:0] r_ir;
    logic       r_bypass;
    logic       r_tdo;
    logic       r_tdo_en;
    logic       w_sel1;
    logic       w_sel2;
    logic       w_in_shir;
    logic       w_in_shdr;
    logic       w_in_capdr;
    logic       w_in_capir;
    logic       w_tdo_mux;
`ifdef JTAG_IDCODE_EN
    logic [31:0] r_idcode;
    logic        w_sel_id;
`endif

    assign w_next     = f_next(r_state, TMS);
    assign w_in_shir  = (r_state == S_SHIR);
    assign w_in_shdr  = (r_state == S_SHDR);
    assign w_in_capdr = (r_state == S_CAPDR);
    assign w_in_capir = (r_state == S_CAPIR);
    assign w_sel1     = (r_ir == USER1_CODE);
    assign w_sel2     = (r_ir == USER2_CODE);
`ifdef JTAG_IDCODE_EN
    assign w_sel_id   = (r_ir == IR_IDCODE);
`endif

    // TAP state machine; the state decodes are registered from the next state
    // so they change on the same rising edge as the state itself.
    always_ff @(posedge TCK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_TLR;
            r_reset   <= 1'b1;
            r_runtest <= 1'b0;
            r_capture <= 1'b0;
            r_shift   <= 1'b0;
            r_update  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_reset   <= (w_next == S_TLR);
            r_runtest <= (w_next == S_RTI);
            r_capture <= (w_next == S_CAPDR);
            r_shift   <= (w_next == S_SHDR);
            r_update  <= (w_next == S_UPDDR);
        end
    end

    // IR shift stage: capture the fixed 0..01 pattern, shift LSB-first with TDI at MSB.
    always_ff @(posedge TCK or negedge RST_N) begin
        if (!RST_N) begin
            r_ir_sr <= IR_CAPTURE;
        end else if (w_in_capir) begin
            r_ir_sr <= IR_CAPTURE;
        end else if (w_in_shir) begin
            r_ir_sr <= {TDI, r_ir_sr[9:1]};
        end
    end

    // Active IR, updated on falling TCK so SELn switches mid-UpdIR.
    always_ff @(negedge TCK or negedge RST_N) begin
        if (!RST_N) begin
            r_ir <= IR_RESET;
        end else if (r_state == S_TLR) begin
            r_ir <= IR_RESET;
        end else if (r_state == S_UPDIR) begin
            r_ir <= r_ir_sr;
        end
    end

    // One-bit bypass register.
    always_ff @(posedge TCK or negedge RST_N) begin
        if (!RST_N) begin
            r_bypass <= 1'b0;
        end else if (w_in_capdr) begin
`ifdef JTAG_IDCODE_EN
            r_bypass <= 1'b0;
`else
            r_bypass <= BYP_CAPTURE;
`endif
        end else if (w_in_shdr) begin
            r_bypass <= TDI;
        end
    end

`ifdef JTAG_IDCODE_EN
    // 32-bit device ID register, loaded in CapDR and shifted LSB-first.
    always_ff @(posedge TCK or negedge RST_N) begin
        if (!RST_N) begin
            r_idcode <= IDCODE_VAL;
        end else if (w_in_capdr && w_sel_id) begin
            r_idcode <= IDCODE_VAL;
        end else if (w_in_shdr && w_sel_id) begin
            r_idcode <= {TDI, r_idcode[31:1]};
        end
    end
`endif

    // Serial-out source: IR in ShIR, fabric chain in a user ShDR, else internal DR.
    always_comb begin
        w_tdo_mux = r_bypass;
`ifdef JTAG_IDCODE_EN
        if (w_sel_id) begin
            w_tdo_mux = r_idcode[0];
        end
`endif
        if (w_in_shdr && w_sel1) begin
            w_tdo_mux = TDO1;
        end else if (w_in_shdr && w_sel2) begin
            w_tdo_mux = TDO2;
        end
        if (w_in_shir) begin
            w_tdo_mux = r_ir_sr[0];
        end
    end

    // TDO and its enable are launched on falling TCK.
    always_ff @(negedge TCK or negedge RST_N) begin
        if (!RST_N) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo    <= w_tdo_mux;
            r_tdo_en <= w_in_shir || w_in_shdr;
        end
    end

    assign TDO      = r_tdo;
    assign TDO_EN   = r_tdo_en;

    assign SEL1     = w_sel1;
    assign SEL2     = w_sel2;
    assign RESET1   = r_reset;
    assign RESET2   = r_reset;
    assign RUNTEST1 = r_runtest;
    assign RUNTEST2 = r_runtest;
    assign CAPTURE1 = r_capture;
    assign CAPTURE2 = r_capture;
    assign SHIFT1   = r_shift;
    assign SHIFT2   = r_shift;
    assign UPDATE1  = r_update;
    assign UPDATE2  = r_update;
    assign TCK1     = TCK;
    assign TCK2     = TCK;
    assign TDI1     = TDI;
    assign TDI2     = TDI;
    assign TMS1     = TMS;
    assign TMS2     = TMS;

    // DRCK follows TCK only while the chain is selected in CapDR/ShDR, idling high.
    assign DRCK1 = (w_sel1 && (r_capture || r_shift)) ? TCK : 1'b1;
    assign DRCK2 = (w_sel2 && (r_capture || r_shift)) ? TCK : 1'b1;

endmodule

// File: tb/tb_jtag_dual_user_tap.sv
// Directed bench for jtag_dual_user_tap: reset entry, USER1/USER2 DR shifts,
// IR capture pattern, bypass delay and asynchronous reset mid-shift.
module tb_jtag_dual_user_tap;

    logic TCK = 1'b0;
    logic RST_N, TMS, TDI, TDO1, TDO2;
    logic TDO, TDO_EN;
    logic CAPTURE1, DRCK1, RESET1, RUNTEST1, SEL1, SHIFT1, UPDATE1, TCK1, TDI1, TMS1;
    logic CAPTURE2, DRCK2, RESET2, RUNTEST2, SEL2, SHIFT2, UPDATE2, TCK2, TDI2, TMS2;

    int n_total = 0;
    int n_bad   = 0;

    // Per-tick observations taken in the low phase of TCK
    logic [63:0] tdo_log;
    logic [63:0] tdi1_log;
    logic [63:0] tdi2_log;
    int          n_tdo;
    int          n_tdi;
    int          c_drck1, c_drck2, c_shift, c_upd, c_tdoen;
    logic [1:0]  sel_pre_upd;
    logic [1:0]  sel_in_upd;
    logic [1:0]  lo_sel;

    jtag_dual_user_tap dut (
        .TCK(TCK), .RST_N(RST_N), .TMS(TMS), .TDI(TDI), .TDO1(TDO1), .TDO2(TDO2),
        .TDO(TDO), .TDO_EN(TDO_EN),
        .CAPTURE1(CAPTURE1), .DRCK1(DRCK1), .RESET1(RESET1), .RUNTEST1(RUNTEST1),
        .SEL1(SEL1), .SHIFT1(SHIFT1), .UPDATE1(UPDATE1), .TCK1(TCK1), .TDI1(TDI1), .TMS1(TMS1),
        .CAPTURE2(CAPTURE2), .DRCK2(DRCK2), .RESET2(RESET2), .RUNTEST2(RUNTEST2),
        .SEL2(SEL2), .SHIFT2(SHIFT2), .UPDATE2(UPDATE2), .TCK2(TCK2), .TDI2(TDI2), .TMS2(TMS2)
    );

    always #5 TCK = ~TCK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        tdo_log = '0; tdi1_log = '0; tdi2_log = '0;
        n_tdo = 0; n_tdi = 0;
        c_drck1 = 0; c_drck2 = 0; c_shift = 0; c_upd = 0; c_tdoen = 0;
    endtask

    // One TCK cycle: drive on falling edge, observe in low phase, settle after rising edge.
    task automatic tick(input logic tms, input logic tdi);
        @(negedge TCK);
        TMS = tms;
        TDI = tdi;
        #1;
        if (n_tdo < 64) tdo_log[n_tdo] = TDO;
        n_tdo++;
        if (TDO_EN) c_tdoen++;
        if (!DRCK1) c_drck1++;
        if (!DRCK2) c_drck2++;
        if (UPDATE2) c_upd++;
        if (SHIFT1) begin
            c_shift++;
            if (n_tdi < 64) begin
                tdi1_log[n_tdi] = TDI1;
                tdi2_log[n_tdi] = TDI2;
            end
            n_tdi++;
        end
        lo_sel = {SEL2, SEL1};
        @(posedge TCK);
        #1;
    endtask

    // From RTI: load a 10-bit instruction and return to RTI.
    task automatic load_ir(input logic [9:0] code);
        clear_logs();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(i == 9, code[i]);
        tick(1'b1, 1'b0);
        sel_pre_upd = {SEL2, SEL1};
        tick(1'b0, 1'b0);
        sel_in_upd = lo_sel;
        tick(1'b0, 1'b0);
    endtask

    // From RTI: capture and shift n DR bits LSB first, update, back to RTI.
    task automatic shift_dr(input logic [31:0] data, input int n);
        clear_logs();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick(i == n - 1, data[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        RST_N = 1'b0; TMS = 1'b1; TDI = 1'b0; TDO1 = 1'b0; TDO2 = 1'b0;
        clear_logs();
        #12;
        check("rst_reset", {30'd0, RESET2, RESET1}, 32'd3);
        check("rst_runtest", {30'd0, RUNTEST2, RUNTEST1}, 32'd0);
        check("rst_cap_sh_upd", {26'd0, CAPTURE1, CAPTURE2, SHIFT1, SHIFT2, UPDATE1, UPDATE2}, 32'd0);
        check("rst_drck", {30'd0, DRCK2, DRCK1}, 32'd3);
        check("rst_sel", {30'd0, SEL2, SEL1}, 32'd0);
        check("rst_tdo", {30'd0, TDO_EN, TDO}, 32'd0);
        RST_N = 1'b1;

        // Reset entry: six TMS=1 then TMS=0
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0);
            check("entry_reset", {30'd0, RESET2, RESET1}, 32'd3);
        end
        tick(1'b0, 1'b0);
        check("entry_runtest", {30'd0, RUNTEST2, RUNTEST1}, 32'd3);
        check("entry_reset_low", {30'd0, RESET2, RESET1}, 32'd0);
        tick(1'b0, 1'b0);
        check("entry_runtest2", {30'd0, RUNTEST2, RUNTEST1}, 32'd3);
        check("entry_sel", {30'd0, SEL2, SEL1}, 32'd0);

        // Instruction selected by TLR
`ifdef JTAG_IDCODE_EN
        shift_dr(32'h0, 8);
        check("tlr_idcode", {24'd0, tdo_log[10:3]}, 32'h93);
`else
        shift_dr(32'h3, 2);
        check("tlr_bypass", {30'd0, tdo_log[4], tdo_log[3]}, 32'd2);
`endif

        // USER1 function code
        TDO1 = 1'b1; TDO2 = 1'b0;
        load_ir(10'h3C2);
        check("u1_ir_capture", {29'd0, tdo_log[6:4]}, 32'd1);
        check("u1_ir_tdoen", c_tdoen, 32'd10);
        check("u1_sel_before_fall", {30'd0, sel_pre_upd}, 32'd0);
        check("u1_sel_at_fall", {30'd0, sel_in_upd}, 32'd1);
        shift_dr(32'h0C, 8);
        check("u1_sel", {30'd0, SEL2, SEL1}, 32'd1);
        check("u1_shift_cnt", c_shift, 32'd8);
        check("u1_tdi", {24'd0, tdi1_log[7:0]}, 32'h0C);
        check("u1_drck1", c_drck1, 32'd9);
        check("u1_drck2", c_drck2, 32'd0);
        check("u1_tdo_pass", {31'd0, tdo_log[3]}, 32'd1);

        // USER2 mask
        TDO1 = 1'b0; TDO2 = 1'b1;
        load_ir(10'h3C3);
        check("u2_sel_at_fall", {30'd0, sel_in_upd}, 32'd2);
        shift_dr(32'h95B, 12);
        check("u2_sel", {30'd0, SEL2, SEL1}, 32'd2);
        check("u2_tdi", {20'd0, tdi2_log[11:0]}, 32'h95B);
        check("u2_update", c_upd, 32'd1);
        check("u2_drck2", c_drck2, 32'd13);
        check("u2_drck1", c_drck1, 32'd0);
        check("u2_tdo_pass", {31'd0, tdo_log[3]}, 32'd1);

        // Bypass with a non-user opcode
        TDO1 = 1'b1; TDO2 = 1'b1;
        load_ir(10'h3E2);
        check("byp_sel", {30'd0, SEL2, SEL1}, 32'd0);
        shift_dr(32'h5, 3);
        check("byp_tdo", {28'd0, tdo_log[6:3]}, 32'hA);
        check("byp_tdoen", c_tdoen, 32'd3);

        // Asynchronous reset in the middle of a USER1 DR shift
        TDO1 = 1'b1; TDO2 = 1'b0;
        load_ir(10'h3C2);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        @(negedge TCK);
        #1;
        check("ar_pre_drck1", {31'd0, DRCK1}, 32'd0);
        check("ar_pre_shift", {31'd0, SHIFT1}, 32'd1);
        RST_N = 1'b0;
        #1;
        check("ar_sel", {30'd0, SEL2, SEL1}, 32'd0);
        check("ar_shift", {31'd0, SHIFT1}, 32'd0);
        check("ar_reset", {31'd0, RESET1}, 32'd1);
        check("ar_drck1", {31'd0, DRCK1}, 32'd1);
        check("ar_tdo", {30'd0, TDO_EN, TDO}, 32'd0);
        #1;
        RST_N = 1'b1;
        tick(1'b0, 1'b0);
        check("ar_after_runtest", {31'd0, RUNTEST1}, 32'd1);
        check("ar_after_sel", {30'd0, SEL2, SEL1}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
